// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard and sequencing controller for the 5-stage
//             RISC-V core. Drives the stall/flush controls of the PC and the
//             IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Four
//             conditions are resolved in fixed priority:
//               1. data-memory wait          (mem_busy)
//               2. halt after a fetch error  (HALT state)
//               3. taken redirect + refetch shadow
//               4. load-use hazard, then fetch-error entry into HALT
//             A saturating 16-bit counter records the cycles with PC held.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FLUSH_CYCLES    : cycles IF/ID is flushed after a taken redirect.
//                      Legal range 1..4 (instruction memory latency + 1).
//  Ports
//    clk             in   1  core clock
//    rst             in   1  synchronous active-high reset
//    id_rs1/id_rs2   in   5  source register fields of the ID instruction
//    id_uses_rs1/2   in   1  ID instruction actually reads rs1 / rs2
//    id_err          in   1  fetch-error flag leaving IF/ID
//    ex_rd           in   5  destination register of the EX instruction
//    ex_mem_read     in   1  EX instruction is a load
//    ex_branch_taken in   1  EX resolved a taken branch/jump this cycle
//    mem_busy        in   1  data memory not ready, MEM must hold
//    pc_stall        out  1  hold PC
//    if_id_stall     out  1  hold IF/ID
//    if_id_flush     out  1  bubble into IF/ID
//    id_ex_stall     out  1  hold ID/EX
//    id_ex_flush     out  1  bubble into ID/EX
//    ex_mem_stall    out  1  hold EX/MEM
//    mem_wb_flush    out  1  bubble into MEM/WB
//    halted          out  1  core halted on a fetch error
//    stall_count     out 16  saturating count of cycles with pc_stall=1
// ============================================================================
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_err,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  // Value loaded into the shadow counter on a taken redirect. The redirect
  // cycle itself is the first flushed cycle, so the shadow covers the rest.
  localparam logic [1:0] C_SHADOW_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam bit         C_HAS_SHADOW  = (FLUSH_CYCLES > 1);

  state_t      state_q,  state_d;
  logic [1:0]  shadow_q, shadow_d;
  logic [15:0] count_q,  count_d;

  logic w_lu;
  logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall;
  logic w_id_ex_flush, w_ex_mem_stall, w_mem_wb_flush;
  logic w_count_inc;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // x0 is never a real dependency.
  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

  // --------------------------------------------------------------------------
  // Next-state and Mealy control decode, first match wins.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_mem_wb_flush = 1'b0;

    if (mem_busy) begin
      // Freeze everything up to MEM and drop a bubble into WB. State and
      // shadow hold so a pending redirect window is extended, not consumed.
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      // Front end frozen; bubbles into EX let older instructions drain.
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Younger instructions are on the wrong path, so lu/id_err are moot.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      if (C_HAS_SHADOW) begin
        state_d  = ST_REDIRECT;
        shadow_d = C_SHADOW_LOAD;
      end else begin
        state_d  = ST_RUN;
      end
    end else if (state_q == ST_REDIRECT) begin
      // Instruction memory still returning wrong-path fetches.
      w_if_id_flush = 1'b1;
      shadow_d      = shadow_q - 2'd1;
      // A zero shadow is unreachable but is treated as the last cycle.
      if (shadow_q <= 2'd1) begin
        state_d  = ST_RUN;
        shadow_d = 2'd0;
      end
    end else if (w_lu) begin
      // One bubble: next cycle EX holds the bubble and the hazard is gone.
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (id_err) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
      state_d       = ST_HALT;
    end
  end

  // Fetch-stall cycles are counted everywhere except in HALT, where the
  // core is dead and the count would only measure idle time.
  assign w_count_inc = w_pc_stall && (state_q != ST_HALT);

  always_comb begin
    count_d = count_q;
    if (w_count_inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      shadow_q <= 2'd0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. While rst is asserted the whole pipeline is forced to bubbles
  // regardless of the (possibly stale) state register.
  // --------------------------------------------------------------------------
  always_comb begin
    if (rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_stall = 1'b0;
      mem_wb_flush = 1'b1;
      halted       = 1'b0;
    end else begin
      pc_stall     = w_pc_stall;
      if_id_stall  = w_if_id_stall;
      if_id_flush  = w_if_id_flush;
      id_ex_stall  = w_id_ex_stall;
      id_ex_flush  = w_id_ex_flush;
      ex_mem_stall = w_ex_mem_stall;
      mem_wb_flush = w_mem_wb_flush;
      halted       = (state_q == ST_HALT);
    end
  end

  assign stall_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl (FLUSH_CYCLES=3). Each
//             step drives one cycle of inputs and queues the expected
//             control vector and stall count; the value is popped and
//             compared on the falling edge of the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int C_FC = 3;

  // Expected control vectors, bit order:
  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //  ex_mem_stall, mem_wb_flush, halted}
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_BR   = 8'b0010_1000;
  localparam logic [7:0] C_RED  = 8'b0010_0000;
  localparam logic [7:0] C_MB   = 8'b1101_0110;
  localparam logic [7:0] C_HLT  = 8'b1100_1001;
  localparam logic [7:0] C_MBH  = 8'b1101_0111;
  localparam logic [7:0] C_RST  = 8'b0010_1010;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_err;
  logic        ex_mem_read, ex_branch_taken, mem_busy;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic        id_ex_flush, ex_mem_stall, mem_wb_flush, halted;
  logic [15:0] stall_count;

  hazard_ctrl #(.FLUSH_CYCLES(C_FC)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_err          (id_err),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_flush    (mem_wb_flush),
    .halted          (halted),
    .stall_count     (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        err;
    logic        bt;
    logic        mb;
    logic [7:0]  ctl;
    logic [15:0] cnt;
  } step_t;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [7:0] obs_ctl;
  assign obs_ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                    id_ex_flush, ex_mem_stall, mem_wb_flush, halted};

  function automatic step_t mk(input logic r, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic err,
                               input logic bt, input logic mb,
                               input logic [7:0] ctl, input logic [15:0] cnt);
    step_t s;
    s.rst = r;  s.mr = mr;  s.rd = rd;  s.rs1 = rs1; s.rs2 = rs2;
    s.u1 = u1;  s.u2 = u2;  s.err = err; s.bt = bt;  s.mb = mb;
    s.ctl = ctl; s.cnt = cnt;
    return s;
  endfunction

  // Idle-input step and load-use step (rd=5 matched through rs2).
  function automatic step_t idle(input logic [7:0] ctl, input logic [15:0] cnt);
    return mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, ctl, cnt);
  endfunction

  function automatic step_t lu(input logic mb, input logic [7:0] ctl, input logic [15:0] cnt);
    return mk(0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, mb, ctl, cnt);
  endfunction

  task automatic drive(input step_t s);
    rst             = s.rst;
    ex_mem_read     = s.mr;
    ex_rd           = s.rd;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    id_uses_rs1     = s.u1;
    id_uses_rs2     = s.u2;
    id_err          = s.err;
    ex_branch_taken = s.bt;
    mem_busy        = s.mb;
    sb.push_back({s.ctl, s.cnt});
  endtask

  task automatic test_reset();
    step_t t[$];
    exp_t  e;
    t.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RST, 16'd0));
    t.push_back(idle(C_IDLE, 16'd0));
    t.push_back(idle(C_IDLE, 16'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if ({obs_ctl, stall_count} !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                 i, obs_ctl, stall_count, e.ctl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    exp_t  e;
    t.push_back(lu(0, C_LU, 16'd0));
    t.push_back(idle(C_IDLE, 16'd1));
    t.push_back(mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, C_IDLE, 16'd1)); // x0
    t.push_back(mk(0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0, C_LU,   16'd1)); // rs1
    t.push_back(mk(0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0, 0, C_IDLE, 16'd2)); // rs1 unused
    t.push_back(mk(0, 0, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0, C_IDLE, 16'd2)); // not a load
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if ({obs_ctl, stall_count} !== e) begin
        n_bad++;
        $display("FAIL load_use[%0d]: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                 i, obs_ctl, stall_count, e.ctl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    step_t t[$];
    exp_t  e;
    step_t br;
    br = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, C_BR, 16'd2);
    // plain window of FLUSH_CYCLES
    t.push_back(br);
    t.push_back(idle(C_RED, 16'd2));
    t.push_back(idle(C_RED, 16'd2));
    t.push_back(idle(C_IDLE, 16'd2));
    // mem_busy in the second cycle stretches the window
    t.push_back(br);
    t.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, C_MB, 16'd2));
    t.push_back(idle(C_RED, 16'd3));
    t.push_back(idle(C_RED, 16'd3));
    t.push_back(idle(C_IDLE, 16'd3));
    // new redirect inside the window reloads the shadow
    br.cnt = 16'd3;
    t.push_back(br);
    t.push_back(idle(C_RED, 16'd3));
    t.push_back(br);
    t.push_back(idle(C_RED, 16'd3));
    t.push_back(idle(C_RED, 16'd3));
    t.push_back(idle(C_IDLE, 16'd3));
    // load-use and fetch error ignored while flushing
    t.push_back(br);
    t.push_back(lu(0, C_RED, 16'd3));
    t.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, C_RED, 16'd3));
    t.push_back(idle(C_IDLE, 16'd3));
    // reset in the middle of a window
    t.push_back(br);
    t.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RST, 16'd3));
    t.push_back(idle(C_IDLE, 16'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if ({obs_ctl, stall_count} !== e) begin
        n_bad++;
        $display("FAIL redirect[%0d]: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                 i, obs_ctl, stall_count, e.ctl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    step_t t[$];
    exp_t  e;
    step_t er;
    er = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, C_LU, 16'd0);
    t.push_back(er);
    t.push_back(idle(C_HLT, 16'd1));
    t.push_back(idle(C_HLT, 16'd1));
    t.push_back(lu(0, C_HLT, 16'd1));
    t.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, C_HLT, 16'd1)); // no exit by branch
    t.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, C_MBH, 16'd1));
    t.push_back(idle(C_HLT, 16'd1));
    t.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RST, 16'd1));
    t.push_back(idle(C_IDLE, 16'd0));
    t.push_back(idle(C_IDLE, 16'd0));
    // error coincident with a redirect: no halt
    t.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, C_BR, 16'd0));
    t.push_back(idle(C_RED, 16'd0));
    t.push_back(idle(C_RED, 16'd0));
    t.push_back(idle(C_IDLE, 16'd0));
    // error under mem_busy waits, then halts
    t.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, C_MB, 16'd0));
    t.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, C_LU, 16'd1));
    t.push_back(idle(C_HLT, 16'd2));
    t.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RST, 16'd2));
    t.push_back(idle(C_IDLE, 16'd0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if ({obs_ctl, stall_count} !== e) begin
        n_bad++;
        $display("FAIL halt[%0d]: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                 i, obs_ctl, stall_count, e.ctl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    exp_t  e;
    for (int k = 0; k < 5; k++) begin
      t.push_back(lu(1, C_MB, 16'(k)));
    end
    t.push_back(lu(0, C_LU, 16'd5));
    t.push_back(idle(C_IDLE, 16'd6));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if ({obs_ctl, stall_count} !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                 i, obs_ctl, stall_count, e.ctl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    drive(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_RST, 16'd6));
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if ({obs_ctl, stall_count} !== e) begin
      n_bad++;
      $display("FAIL sat_reset: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
               obs_ctl, stall_count, e.ctl, e.cnt);
    end
    @(posedge clk); #1;
    // Load-use held continuously stalls every cycle; count must stop at FFFF.
    for (int k = 0; k < 65540; k++) begin
      drive(lu(0, C_LU, (k > 65535) ? 16'hFFFF : 16'(k)));
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if ({obs_ctl, stall_count} !== e) begin
        n_bad++;
        $display("FAIL saturate[%0d]: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                 k, obs_ctl, stall_count, e.ctl, e.cnt);
      end
      @(posedge clk); #1;
    end
    drive(idle(C_IDLE, 16'hFFFF));
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if ({obs_ctl, stall_count} !== e) begin
      n_bad++;
      $display("FAIL sat_hold: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
               obs_ctl, stall_count, e.ctl, e.cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_halt();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
